// File: rtl/control_sequencer.sv
// Hardwired control sequencer for a single-bus CPU datapath: fetches one
// instruction per start request and steps it through T0..T6 with Moore-decoded strobes.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        mem_rdy,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        Cout,
    output logic        Rout,
    output logic        MARin,
    output logic        PCin,
    output logic        IRin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        Rin,
    output logic        Read,
    output logic        IncPC,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic [4:0]  alu_op,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T0   = 3'd1,
        T1   = 3'd2,
        T2   = 3'd3,
        T3   = 3'd4,
        T4   = 3'd5,
        T5   = 3'd6,
        T6   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_R3,
        C_IMM,
        C_MD,
        C_UN,
        C_MFHI,
        C_MFLO,
        C_ILL
    } op_class_t;

    state_t    state, state_nxt;
    op_class_t op_class;
    logic [4:0] opcode;
    logic       t1_wait;
    logic       unused_ir;

    assign opcode = ir[31:27];
    // Register fields are consumed by the datapath, not by the sequencer.
    assign unused_ir = ^ir[26:0];

    always_comb begin
        if (opcode <= 5'd8)
            op_class = C_R3;
        else if (opcode <= 5'd11)
            op_class = C_IMM;
        else if (opcode <= 5'd13)
            op_class = C_MD;
        else if (opcode <= 5'd15)
            op_class = C_UN;
        else if (opcode == 5'd16)
            op_class = C_MFHI;
        else if (opcode == 5'd17)
            op_class = C_MFLO;
        else
            op_class = C_ILL;
    end

    // t1_wait marks the second and later cycles of a stalled memory read so
    // that PC is written back only once.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state   <= IDLE;
            t1_wait <= 1'b0;
        end else begin
            state   <= state_nxt;
            t1_wait <= (state == T1) && (state_nxt == T1);
        end
    end

    always_comb begin
        state_nxt = IDLE;
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        Zhighout  = 1'b0;
        MDRout    = 1'b0;
        HIout     = 1'b0;
        LOout     = 1'b0;
        Cout      = 1'b0;
        Rout      = 1'b0;
        MARin     = 1'b0;
        PCin      = 1'b0;
        IRin      = 1'b0;
        MDRin     = 1'b0;
        Yin       = 1'b0;
        Zin       = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        Rin       = 1'b0;
        Read      = 1'b0;
        IncPC     = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        alu_op    = 5'd0;
        done      = 1'b0;
        illegal   = 1'b0;

        case (state)
            IDLE: state_nxt = start ? T0 : IDLE;
            T0: begin
                PCout     = 1'b1;
                MARin     = 1'b1;
                IncPC     = 1'b1;
                Zin       = 1'b1;
                state_nxt = T1;
            end
            T1: begin
                Zlowout   = 1'b1;
                PCin      = !t1_wait;
                Read      = 1'b1;
                MDRin     = 1'b1;
                state_nxt = mem_rdy ? T2 : T1;
            end
            T2: begin
                MDRout    = 1'b1;
                IRin      = 1'b1;
                state_nxt = T3;
            end
            T3: begin
                case (op_class)
                    C_R3, C_IMM: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                        state_nxt = T4;
                    end
                    C_MD: begin
                        Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                        state_nxt = T4;
                    end
                    C_UN: begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
                        state_nxt = T4;
                    end
                    C_MFHI: begin
                        HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                    end
                    C_MFLO: begin
                        LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            T4: begin
                case (op_class)
                    C_R3: begin
                        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
                        state_nxt = T5;
                    end
                    C_IMM: begin
                        Cout = 1'b1; Zin = 1'b1; alu_op = opcode;
                        state_nxt = T5;
                    end
                    C_MD: begin
                        Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode;
                        state_nxt = T5;
                    end
                    C_UN: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
            T5: begin
                case (op_class)
                    C_R3, C_IMM: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; done = 1'b1;
                    end
                    C_MD: begin
                        Zlowout = 1'b1; LOin = 1'b1;
                        state_nxt = T6;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer: per-opcode latency and
// strobe checks, plus hand sequences for reset mid-instruction and back-to-back starts.
module tb_control_sequencer;

    logic clock = 1'b0, clear, start, mem_rdy;
    logic [31:0] ir;
    logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, Rout;
    logic MARin, PCin, IRin, MDRin, Yin, Zin, HIin, LOin, Rin, Read, IncPC;
    logic Gra, Grb, Grc, busy, done, illegal;
    logic [4:0] alu_op;
    logic [24:0] sig;

    int total = 0;
    int bad   = 0;

    control_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .ir(ir), .mem_rdy(mem_rdy),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .Rout(Rout),
        .MARin(MARin), .PCin(PCin), .IRin(IRin), .MDRin(MDRin), .Yin(Yin),
        .Zin(Zin), .HIin(HIin), .LOin(LOin), .Rin(Rin), .Read(Read), .IncPC(IncPC),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .alu_op(alu_op),
        .busy(busy), .done(done), .illegal(illegal)
    );

    always #5 clock = ~clock;

    assign sig = {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, Rout,
                  MARin, PCin, IRin, MDRin, Yin, Zin, HIin, LOin, Rin, Read, IncPC,
                  Gra, Grb, Grc, done, illegal, busy};

    localparam logic [24:0] PCOUT = 25'h1 << 24, ZLO = 25'h1 << 23, ZHI = 25'h1 << 22,
        MDROUT = 25'h1 << 21, HIOUT = 25'h1 << 20, LOOUT = 25'h1 << 19, COUT = 25'h1 << 18,
        ROUT = 25'h1 << 17, MARIN = 25'h1 << 16, PCIN = 25'h1 << 15, IRIN = 25'h1 << 14,
        MDRIN = 25'h1 << 13, YIN = 25'h1 << 12, ZIN = 25'h1 << 11, HIIN = 25'h1 << 10,
        LOIN = 25'h1 << 9, RIN = 25'h1 << 8, READ = 25'h1 << 7, INCPC = 25'h1 << 6,
        GRA = 25'h1 << 5, GRB = 25'h1 << 4, GRC = 25'h1 << 3, DONE = 25'h1 << 2,
        ILL = 25'h1 << 1, BUSY = 25'h1;

    localparam logic [24:0] PRE_R3  = GRC | ROUT | ZIN | BUSY;
    localparam logic [24:0] PRE_IMM = COUT | ZIN | BUSY;
    localparam logic [24:0] PRE_MD  = ZLO | LOIN | BUSY;
    localparam logic [24:0] PRE_UN  = GRB | ROUT | ZIN | BUSY;
    localparam logic [24:0] PRE_MF  = MDROUT | IRIN | BUSY;
    localparam logic [24:0] FIN_WB  = ZLO | GRA | RIN | DONE | BUSY;
    localparam logic [24:0] FIN_MD  = ZHI | HIIN | DONE | BUSY;
    localparam logic [24:0] FIN_HI  = HIOUT | GRA | RIN | DONE | BUSY;
    localparam logic [24:0] FIN_LO  = LOOUT | GRA | RIN | DONE | BUSY;
    localparam logic [24:0] FIN_ILL = ILL | BUSY;
    localparam logic [24:0] T0_VEC  = PCOUT | MARIN | INCPC | ZIN | BUSY;

    typedef struct {
        logic [4:0]  op;
        int          waits;
        int          lat;
        logic [24:0] pre;
        logic [4:0]  pre_alu;
        logic [24:0] fin;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called at a falling edge with the sequencer idle; returns at the falling
    // edge of the done/illegal cycle.
    task automatic run_instr(input logic [4:0] op, input int waits, output int lat,
                             output logic [24:0] pre, output logic [24:0] fin,
                             output logic [4:0] pre_alu, output logic [4:0] fin_alu,
                             output int reads, output int pcins);
        logic [24:0] prev_s;
        logic [4:0]  prev_a;
        int n;
        lat = 0; reads = 0; pcins = 0; n = 0;
        pre = '0; fin = '0; pre_alu = '0; fin_alu = '0; prev_s = '0; prev_a = '0;
        ir = {op, 27'h2a5c3e1};
        start = 1'b1;
        mem_rdy = 1'b0;
        @(negedge clock);
        start = 1'b0;
        while (n < 40) begin
            n++;
            lat++;
            if (sig[7]) begin
                reads++;
                mem_rdy = (reads > waits);
            end
            if (sig[15]) pcins++;
            if (sig[2] | sig[1]) begin
                pre = prev_s; pre_alu = prev_a; fin = sig; fin_alu = alu_op;
                break;
            end
            prev_s = sig;
            prev_a = alu_op;
            @(negedge clock);
        end
        mem_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int lat, reads, pcins, viol;
        logic [24:0] pre, fin;
        logic [4:0] pre_alu, fin_alu;

        tbl[0]  = '{5'd0,  0, 6,  PRE_R3,  5'd0,  FIN_WB};
        tbl[1]  = '{5'd1,  2, 8,  PRE_R3,  5'd1,  FIN_WB};
        tbl[2]  = '{5'd8,  0, 6,  PRE_R3,  5'd8,  FIN_WB};
        tbl[3]  = '{5'd9,  0, 6,  PRE_IMM, 5'd9,  FIN_WB};
        tbl[4]  = '{5'd11, 1, 7,  PRE_IMM, 5'd11, FIN_WB};
        tbl[5]  = '{5'd12, 3, 10, PRE_MD,  5'd0,  FIN_MD};
        tbl[6]  = '{5'd13, 0, 7,  PRE_MD,  5'd0,  FIN_MD};
        tbl[7]  = '{5'd14, 0, 5,  PRE_UN,  5'd14, FIN_WB};
        tbl[8]  = '{5'd15, 2, 7,  PRE_UN,  5'd15, FIN_WB};
        tbl[9]  = '{5'd16, 0, 4,  PRE_MF,  5'd0,  FIN_HI};
        tbl[10] = '{5'd17, 1, 5,  PRE_MF,  5'd0,  FIN_LO};
        tbl[11] = '{5'd18, 0, 4,  PRE_MF,  5'd0,  FIN_ILL};
        tbl[12] = '{5'd31, 0, 4,  PRE_MF,  5'd0,  FIN_ILL};

        // Reset state, and start ignored while clear is low
        clear = 1'b0; start = 1'b1; mem_rdy = 1'b1; ir = '0;
        @(negedge clock);
        @(negedge clock);
        chk("reset_outputs", sig, 25'h0);
        chk("reset_alu_op", alu_op, 5'd0);
        start = 1'b0;
        clear = 1'b1;
        @(negedge clock);
        chk("idle_after_release", sig, 25'h0);

        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].waits, lat, pre, fin, pre_alu, fin_alu, reads, pcins);
            chk($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("v%0d_pre_sigs", i), pre, tbl[i].pre);
            chk($sformatf("v%0d_pre_alu", i), pre_alu, tbl[i].pre_alu);
            chk($sformatf("v%0d_fin_sigs", i), fin, tbl[i].fin);
            chk($sformatf("v%0d_fin_alu", i), fin_alu, 5'd0);
            chk($sformatf("v%0d_read_cycles", i), reads, tbl[i].waits + 1);
            chk($sformatf("v%0d_pcin_cycles", i), pcins, 1);
            @(negedge clock);
            chk($sformatf("v%0d_idle_after", i), sig, 25'h0);
        end

        // Asynchronous clear in the middle of T4 of sub
        ir = {5'd1, 27'h0};
        start = 1'b1; mem_rdy = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("sub_t0", sig, T0_VEC);
        repeat (4) @(negedge clock);
        chk("sub_t4", sig, PRE_R3);
        chk("sub_t4_alu", alu_op, 5'd1);
        #2 clear = 1'b0;
        #1;
        chk("clear_async_sigs", sig, 25'h0);
        chk("clear_async_alu", alu_op, 5'd0);
        start = 1'b1;
        @(negedge clock);
        chk("clear_held_idle", sig, 25'h0);
        clear = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("fresh_t0", sig, T0_VEC);
        chk("fresh_t0_alu", alu_op, 5'd0);
        lat = 1;
        while (!done && lat < 30) begin
            @(negedge clock);
            lat++;
        end
        chk("fresh_latency", lat, 6);
        @(negedge clock);
        chk("fresh_idle_after", sig, 25'h0);

        // start held high: one idle cycle separates consecutive instructions
        ir = {5'd0, 27'h0};
        start = 1'b1; mem_rdy = 1'b1; viol = 0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clock);
            chk($sformatf("b2b_busy_done_%0d", i), {busy, done},
                {1'(i % 7 != 6), 1'(i % 7 == 5)});
            if ($countones(sig[24:17]) > 1) viol++;
        end
        start = 1'b0;
        chk("b2b_bus_source_conflicts", viol, 0);
        @(negedge clock);
        chk("b2b_final_idle", sig, 25'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
